// File: rtl/sys_defs.sv
// sys_defs: shared execute-stage types (issue entry, CDB payload, ALU functions)
// plus the multiply pipeline packet and helpers used by mult_exec_unit.
package sys_defs;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_W   = 5;
  localparam int MULT_STAGES = 4;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_MUL    = 4'd8,
    ALU_MULH   = 4'd9,
    ALU_MULHSU = 4'd10,
    ALU_MULHU  = 4'd11
  } ALU_FUNC;

  typedef struct packed {
    ALU_FUNC    alu_func;
    logic [4:0] dest_reg;
  } DECODED_INSTR;

  typedef struct packed {
    DECODED_INSTR          instr;
    logic [XLEN-1:0]       rs1_value;
    logic [XLEN-1:0]       rs2_value;
    logic [ROB_TAG_W-1:0]  rd_tag;
  } INSTR_READY_ENTRY;

  typedef struct packed {
    logic                  valid;
    logic [ROB_TAG_W-1:0]  rob_tag;
    logic [XLEN-1:0]       value;
  } CDB_DATA;

  typedef struct packed {
    logic                  valid;
    logic [ROB_TAG_W-1:0]  rob_tag;
    ALU_FUNC               func;
    logic [2*XLEN-1:0]     mcand;
    logic [2*XLEN-1:0]     mplier;
    logic [2*XLEN-1:0]     product;
  } MULT_STAGE_PACKET;

  function automatic logic [XLEN-1:0] mult_select(input ALU_FUNC func,
                                                  input logic [2*XLEN-1:0] product);
    logic [XLEN-1:0] r;
    case (func)
      ALU_MUL:                         r = product[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: r = product[2*XLEN-1:XLEN];
      default:                         r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  function automatic MULT_STAGE_PACKET mult_prep(input INSTR_READY_ENTRY e);
    MULT_STAGE_PACKET p;
    logic rs1_signed;
    logic rs2_signed;
    case (e.instr.alu_func)
      ALU_MUL, ALU_MULH: begin rs1_signed = 1'b1; rs2_signed = 1'b1; end
      ALU_MULHSU:        begin rs1_signed = 1'b1; rs2_signed = 1'b0; end
      default:           begin rs1_signed = 1'b0; rs2_signed = 1'b0; end
    endcase
    p.valid   = 1'b0;
    p.rob_tag = e.rd_tag;
    p.func    = e.instr.alu_func;
    p.mcand   = rs1_signed ? {{XLEN{e.rs1_value[XLEN-1]}}, e.rs1_value}
                           : {{XLEN{1'b0}}, e.rs1_value};
    p.mplier  = {{XLEN{1'b0}}, e.rs2_value};
    // Only the low XLEN multiplier bits get folded; a negative signed rs2
    // contributes -mcand*2^XLEN, which is preloaded into the accumulator.
    p.product = (rs2_signed && e.rs2_value[XLEN-1])
              ? ({(2*XLEN){1'b0}} - (p.mcand << XLEN))
              : {(2*XLEN){1'b0}};
    return p;
  endfunction

endpackage

// File: rtl/mult_stage.sv
// mult_stage: one registered partial-product step; folds CHUNK multiplier bits
// starting at bit IDX*CHUNK into the accumulator unless held.
module mult_stage
  import sys_defs::*;
#(
  parameter int IDX   = 0,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             hold,
  input  MULT_STAGE_PACKET in_pkt,
  output MULT_STAGE_PACKET out_pkt
);

  logic [2*XLEN-1:0] chunk_s;
  logic [2*XLEN-1:0] partial_s;
  MULT_STAGE_PACKET  next_s;

  // Partial product for this stage's slice of the multiplier.
  always_comb begin
    chunk_s              = {(2*XLEN){1'b0}};
    chunk_s[CHUNK-1:0]   = in_pkt.mplier[IDX*CHUNK +: CHUNK];
    partial_s            = in_pkt.mcand * chunk_s;
    next_s               = in_pkt;
    next_s.product       = in_pkt.product + (partial_s << (IDX*CHUNK));
  end

  // Stage register: flush kills the op, hold freezes the whole packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_pkt <= {$bits(MULT_STAGE_PACKET){1'b0}};
    end else if (flush) begin
      out_pkt.valid <= 1'b0;
    end else if (!hold) begin
      out_pkt <= next_s;
    end
  end

endmodule

// File: rtl/mult_exec_unit.sv
// mult_exec_unit: pipelined MUL/MULH/MULHSU/MULHU unit feeding the CDB.
// Define MULT_OUT_QUEUE_EN to add a 2-entry result FIFO after the last stage.
module mult_exec_unit
  import sys_defs::*;
#(
  parameter int STAGES = MULT_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  INSTR_READY_ENTRY issue_entry,
  output logic             issue_ready,
  input  logic             flush,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output CDB_DATA          cdb_out,
  output logic             busy
);

  localparam int CHUNK = XLEN / STAGES;

  MULT_STAGE_PACKET      stage_in_s  [STAGES];
  MULT_STAGE_PACKET      stage_out_s [STAGES];
  MULT_STAGE_PACKET      issue_pkt_s;
  MULT_STAGE_PACKET      final_s;
  logic                  advance_s;
  logic                  ready_s;
  logic                  cdb_req_s;
  logic                  queue_busy_s;
  logic                  stage_busy_s;
  logic [ROB_TAG_W-1:0]  tag_s;
  logic [XLEN-1:0]       value_s;
  logic                  entry_unused_s;

  assign final_s        = stage_out_s[STAGES-1];
  assign entry_unused_s = ^{issue_entry.instr.dest_reg, final_s.mcand, final_s.mplier};

  // Build the stage-0 packet from the RS entry.
  always_comb begin
    issue_pkt_s       = mult_prep(issue_entry);
    issue_pkt_s.valid = issue_valid & ready_s & ~flush;
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_first
        assign stage_in_s[g] = issue_pkt_s;
      end else begin : g_next
        assign stage_in_s[g] = stage_out_s[g-1];
      end
      mult_stage #(.IDX(g), .CHUNK(CHUNK)) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .hold    (~advance_s),
        .in_pkt  (stage_in_s[g]),
        .out_pkt (stage_out_s[g])
      );
    end
  endgenerate

`ifdef MULT_OUT_QUEUE_EN
  logic [1:0]            q_count_r;
  logic                  q_rd_r;
  logic                  q_wr_r;
  logic [ROB_TAG_W-1:0]  q_tag_r [2];
  logic [XLEN-1:0]       q_val_r [2];
  logic                  q_full_s;
  logic                  q_pop_s;
  logic                  q_push_s;

  assign q_full_s     = (q_count_r == 2'd2);
  assign cdb_req_s    = (q_count_r != 2'd0);
  assign q_pop_s      = cdb_req_s & cdb_grant & ~flush;
  assign advance_s    = ~final_s.valid | ~q_full_s | q_pop_s;
  assign q_push_s     = final_s.valid & advance_s & ~flush;
  // Conservative: no grant term, so ready comes straight from registered state.
  assign ready_s      = ~(final_s.valid & q_full_s) | flush;
  assign tag_s        = q_tag_r[q_rd_r];
  assign value_s      = q_val_r[q_rd_r];
  assign queue_busy_s = cdb_req_s;

  // Result FIFO between the last stage and the CDB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_count_r  <= 2'd0;
      q_rd_r     <= 1'b0;
      q_wr_r     <= 1'b0;
      q_tag_r[0] <= {ROB_TAG_W{1'b0}};
      q_tag_r[1] <= {ROB_TAG_W{1'b0}};
      q_val_r[0] <= {XLEN{1'b0}};
      q_val_r[1] <= {XLEN{1'b0}};
    end else if (flush) begin
      q_count_r <= 2'd0;
      q_rd_r    <= 1'b0;
      q_wr_r    <= 1'b0;
    end else begin
      if (q_push_s) begin
        q_tag_r[q_wr_r] <= final_s.rob_tag;
        q_val_r[q_wr_r] <= mult_select(final_s.func, final_s.product);
        q_wr_r          <= ~q_wr_r;
      end
      if (q_pop_s) begin
        q_rd_r <= ~q_rd_r;
      end
      q_count_r <= q_count_r + {1'b0, q_push_s} - {1'b0, q_pop_s};
    end
  end
`else
  assign cdb_req_s    = final_s.valid;
  assign advance_s    = ~(final_s.valid & ~cdb_grant);
  assign ready_s      = advance_s | flush;
  assign tag_s        = final_s.rob_tag;
  assign value_s      = mult_select(final_s.func, final_s.product);
  assign queue_busy_s = 1'b0;
`endif

  // Occupancy across all stages.
  always_comb begin
    stage_busy_s = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      stage_busy_s = stage_busy_s | stage_out_s[i].valid;
    end
  end

  // CDB payload is only driven in the cycle the result actually retires.
  always_comb begin
    cdb_out = {$bits(CDB_DATA){1'b0}};
    if (cdb_req_s & cdb_grant & ~flush) begin
      cdb_out.valid   = 1'b1;
      cdb_out.rob_tag = tag_s;
      cdb_out.value   = value_s;
    end else begin
      cdb_out = {$bits(CDB_DATA){1'b0}};
    end
  end

  assign issue_ready = ready_s;
  assign cdb_req     = cdb_req_s;
  assign busy        = stage_busy_s | queue_busy_s;

endmodule
